pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Decides each cycle whether PC and IF/ID advance, hold or flush, and whether a bubble enters ID/EX.
- Detects load-use hazards, handles EX-stage redirects, and drains the pipe then halts on ECALL.
- Drives the gated opcode into the ID-stage immediate generator so bubbles decode as zero-immediate NOPs.

Parameters:
- FLUSH_CYCLES, 1, cycles ID is squashed after a redirect (fetch latency); legal 1..7
- DRAIN_CYCLES, 3, cycles from ECALL leaving ID until halt (EX/MEM/WB); legal 1..7

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid_i  in  1  IF/ID register holds a valid instruction
- id_insn_i  in  32  instruction in ID
- ex_valid_i  in  1  ID/EX holds a valid instruction
- ex_is_load_i  in  1  EX instruction is a load
- ex_rd_i  in  5  EX destination register
- ex_redirect_i  in  1  branch taken or jump resolved in EX
- mem_busy_i  in  1  data memory not ready; whole pipe freezes
- pc_en_o  out  1  PC register update enable
- ifid_en_o  out  1  IF/ID register load enable
- ifid_flush_o  out  1  clear IF/ID valid
- idex_bubble_o  out  1  load NOP/invalid into ID/EX
- id_opcode_o  out  7  opcode to immediate generator: id_insn_i[6:0], or 7'b0 when ID is squashed or invalid
- halt_o  out  1  sticky core halt

Behaviour:
- Reset (rst_n low, asynchronous): state RUN, counter 0, all outputs 0, including pc_en_o.
- First cycle after release: state is RUN.
- States and counter (3-bit):
  - RUN
  - FLUSH: counter loaded with FLUSH_CYCLES-1
  - DRAIN: counter loaded with DRAIN_CYCLES-1
  - HALT
- Register-use decode, from opcode:
  - rs1 = insn[19:15] used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 = insn[24:20] used by BRANCH, STORE, OP.
- Load-use hazard = id_valid_i & ex_valid_i & ex_is_load_i & ex_rd_i != 0 & (used rs1 == ex_rd_i or used rs2 == ex_rd_i).
- ECALL = id_valid_i & id_insn_i == 32'h0000_0073.
- Priority each cycle, highest first:
  1. mem_busy_i: pc_en=0, ifid_en=0, bubble=0, flush=0. State and counter hold. This applies in every state except HALT.
  2. HALT: pc_en=0, ifid_en=0, bubble=1, flush=1, halt_o=1. Only reset leaves HALT.
  3. ex_redirect_i in RUN or FLUSH: pc_en=1, ifid_en=1, flush=1, bubble=1. Go to FLUSH (reload counter). Redirect in DRAIN is ignored.
  4. FLUSH: pc_en=1, ifid_en=1, flush=1, bubble=1. Decrement the counter; when it is 0, go to RUN. Hazard and ECALL are ignored.
  5. Load-use in RUN: pc_en=0, ifid_en=0, bubble=1, flush=0. This lasts exactly 1 cycle because the bubble removes the load from EX.
  6. ECALL in RUN: pc_en=0, ifid_en=0, flush=1, bubble=0 (ECALL advances to EX). Go to DRAIN.
  7. DRAIN: pc_en=0, ifid_en=0, bubble=1, flush=1. Decrement the counter; at 0 go to HALT, with halt_o=1 from the next cycle.
  8. RUN otherwise: pc_en=1, ifid_en=1, others 0.
- halt_o is registered (state==HALT). All other outputs are combinational from state and inputs.
- id_opcode_o = 0 whenever bubble=1, flush=1, or id_valid_i=0; otherwise id_insn_i[6:0].

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cnt_o (32): counts load-use stall cycles.
  - flush_cnt_o (32): counts cycles with ifid_flush_o=1.
- Both counters reset to 0, wrap at 2^32, and do not count while mem_busy_i is high or in HALT.
- When not defined, neither port nor counter exists.

Test Plan:
- Load-use: EX holds lw x5 (ex_rd_i=5, load); ID holds add x6,x5,x1 (0x00128333) -> exactly 1 cycle with pc_en=0, ifid_en=0, bubble=1, id_opcode_o=0. Next cycle RUN, pc_en=1.
- No false hazard: ex_rd_i=0 with load, and ID holds lui x5 (0x000052B7) with ex_rd_i=5 -> pc_en=1, bubble=0, id_opcode_o=7'h37.
- Redirect, FLUSH_CYCLES=2: ex_redirect_i pulse -> flush=1 and bubble=1 for 3 consecutive cycles (redirect cycle + 2), then RUN.
- ECALL, DRAIN_CYCLES=3: ID=0x00000073 -> flush 1 cycle, then DRAIN 3 cycles, then halt_o=1 and stays high for 10+ cycles. Redirect during DRAIN has no effect.
- mem_busy_i high for 4 cycles during FLUSH -> all enables 0 and the counter frozen. Flush resumes with its remaining count.
- Reset mid-DRAIN: rst_n low asynchronously -> outputs 0 immediately. After release, state RUN and halt_o=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline sequencing bundle between the RV32I datapath (master) and the
// hazard/sequencing controller (slave).
interface pipe_hazard_ctrl_if;
  logic        id_valid_i;
  logic [31:0] id_insn_i;
  logic        ex_valid_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic        ex_redirect_i;
  logic        mem_busy_i;
  logic        pc_en_o;
  logic        ifid_en_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic [6:0]  id_opcode_o;
  logic        halt_o;

  modport master (
    output id_valid_i, id_insn_i, ex_valid_i, ex_is_load_i, ex_rd_i,
           ex_redirect_i, mem_busy_i,
    input  pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o, id_opcode_o, halt_o
  );

  modport slave (
    input  id_valid_i, id_insn_i, ex_valid_i, ex_is_load_i, ex_rd_i,
           ex_redirect_i, mem_busy_i,
    output pc_en_o, ifid_en_o, ifid_flush_o, idex_bubble_o, id_opcode_o, halt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / sequencing controller for the 5-stage RV32I core: load-use stall,
// EX redirect flush, ECALL drain-and-halt. PIPE_HAZARD_PERF_EN adds perf counters.
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       halt_q;

  logic [6:0] opc;
  logic       use_rs1, use_rs2;
  logic       load_use, ecall;
  logic       pc_en, ifid_en, flush, bubble, stall_evt;

  assign opc = bus.id_insn_i[6:0];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: use_rs1 = 1'b1;
      OPC_BRANCH, OPC_STORE, OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign load_use = bus.id_valid_i & bus.ex_valid_i & bus.ex_is_load_i &
                    (bus.ex_rd_i != 5'd0) &
                    ((use_rs1 & (bus.id_insn_i[19:15] == bus.ex_rd_i)) |
                     (use_rs2 & (bus.id_insn_i[24:20] == bus.ex_rd_i)));

  assign ecall = bus.id_valid_i & (bus.id_insn_i == 32'h0000_0073);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= (state_d == HALT);
    end
  end

  // Next state: HALT is absorbing, a busy memory freezes everything else.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != HALT && !bus.mem_busy_i) begin
      if (bus.ex_redirect_i && state_q != DRAIN) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_LOAD;
      end else if (state_q == FLUSH) begin
        if (cnt_q == 3'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end else if (state_q == DRAIN) begin
        if (cnt_q == 3'd0) state_d = HALT;
        else               cnt_d   = cnt_q - 3'd1;
      end else if (!load_use && ecall) begin
        state_d = DRAIN;
        cnt_d   = DRAIN_LOAD;
      end
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    flush     = 1'b0;
    bubble    = 1'b0;
    stall_evt = 1'b0;
    if (!rst_n) begin
      pc_en = 1'b0;
    end else if (state_q == HALT) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (bus.mem_busy_i) begin
      pc_en = 1'b0;
    end else if ((bus.ex_redirect_i && state_q != DRAIN) || state_q == FLUSH) begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      flush   = 1'b1;
      bubble  = 1'b1;
    end else if (state_q == DRAIN) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (load_use) begin
      bubble    = 1'b1;
      stall_evt = 1'b1;
    end else if (ecall) begin
      flush = 1'b1;
    end else begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
    end
  end

  assign bus.pc_en_o       = pc_en;
  assign bus.ifid_en_o     = ifid_en;
  assign bus.ifid_flush_o  = flush;
  assign bus.idex_bubble_o = bubble;
  assign bus.id_opcode_o   = (!rst_n || bubble || flush || !bus.id_valid_i) ? 7'd0 : opc;
  assign bus.halt_o        = halt_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_evt) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && state_q != HALT && !bus.mem_busy_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
